game_ctrl: RTL and testbench

- Round/match sequencer for the pong datapath.
- Starts the match, holds the ball centred during a serve countdown, and enables ball motion during play.
- Takes goal events from the ball block, keeps both scores, pauses after each point, and declares a winner.
- Sits between the player button, the ball block (hold/enable/serve direction) and the score/LED display.

---
 rtl/pong_pkg.sv | 19 +
 rtl/game_ctrl_frame_timer.sv | 26 ++
 rtl/game_ctrl.sv | 134 +++++++++++++
 tb/tb_game_ctrl.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared pong definitions: sequencer state encoding, datapath widths, side constants.
package pong_pkg;

    localparam int unsigned SCORE_W = 4;
    localparam int unsigned CNT_W   = 8;

    localparam logic LEFT  = 1'b0;
    localparam logic RIGHT = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SERVE  = 3'd1,
        ST_PLAY   = 3'd2,
        ST_PAUSED = 3'd3,
        ST_POINT  = 3'd4,
        ST_OVER   = 3'd5
    } state_t;

endpackage

// File: rtl/game_ctrl_frame_timer.sv
// Frame-tick counter; done pulses on the tick that reaches the final count (target).
module frame_timer
    import pong_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             tick,
    input  logic [CNT_W-1:0] target,
    output logic             done
);

    logic [CNT_W-1:0] cnt;

    assign done = tick & (cnt == target);

    always_ff @(posedge clk) begin
        if (!reset)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (tick)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/game_ctrl.sv
// Pong match sequencer: serve countdown, play, pause, post-point freeze, match end.
module game_ctrl
    import pong_pkg::*;
#(
    parameter int unsigned WIN_SCORE    = 7,
    parameter int unsigned SERVE_FRAMES = 60,
    parameter int unsigned POINT_FRAMES = 90
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               start,
    input  logic               goal_l,
    input  logic               goal_r,
    output logic               ball_hold,
    output logic               ball_en,
    output logic               serve_dir,
    output logic [SCORE_W-1:0] score_l,
    output logic [SCORE_W-1:0] score_r,
    output logic [2:0]         state_o,
    output logic               game_over,
    output logic               winner
);

    localparam logic [SCORE_W-1:0] WIN        = SCORE_W'(WIN_SCORE);
    localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
    localparam logic [CNT_W-1:0]   POINT_LAST = CNT_W'(POINT_FRAMES - 1);

    state_t             state, nxt_state;
    logic               start_q, start_rise;
    logic [SCORE_W-1:0] nxt_score_l, nxt_score_r;
    logic               nxt_dir, nxt_over, nxt_winner;
    logic               tmr_clr, tmr_done;
    logic [CNT_W-1:0]   tmr_target;

    assign start_rise = start & ~start_q;
    assign state_o    = state;

    // Timer only runs in SERVE/POINT and restarts from zero on every state entry.
    assign tmr_target = (state == ST_POINT) ? POINT_LAST : SERVE_LAST;
    assign tmr_clr    = ((state != ST_SERVE) && (state != ST_POINT)) || (nxt_state != state);

    frame_timer u_timer (
        .clk    (clk),
        .reset  (reset),
        .clr    (tmr_clr),
        .tick   (frame_tick),
        .target (tmr_target),
        .done   (tmr_done)
    );

    always_comb begin
        nxt_state   = state;
        nxt_score_l = score_l;
        nxt_score_r = score_r;
        nxt_dir     = serve_dir;
        nxt_over    = game_over;
        nxt_winner  = winner;
        unique case (state)
            ST_IDLE, ST_OVER: begin
                if (start_rise) begin
                    nxt_score_l = '0;
                    nxt_score_r = '0;
                    nxt_dir     = LEFT;
                    nxt_over    = 1'b0;
                    nxt_winner  = 1'b0;
                    nxt_state   = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (tmr_done)
                    nxt_state = ST_PLAY;
            end
            ST_PLAY: begin
                // Goals take priority over a pause request in the same cycle.
                if (goal_l || goal_r) begin
                    nxt_state = ST_POINT;
                    if (goal_r && !goal_l) begin
                        if (score_l != WIN)
                            nxt_score_l = score_l + 1'b1;
                        nxt_dir = LEFT;
                    end else if (goal_l && !goal_r) begin
                        if (score_r != WIN)
                            nxt_score_r = score_r + 1'b1;
                        nxt_dir = RIGHT;
                    end
                end else if (start_rise) begin
                    nxt_state = ST_PAUSED;
                end
            end
            ST_PAUSED: begin
                if (start_rise)
                    nxt_state = ST_PLAY;
            end
            ST_POINT: begin
                if (tmr_done) begin
                    if ((score_l == WIN) || (score_r == WIN)) begin
                        nxt_state  = ST_OVER;
                        nxt_over   = 1'b1;
                        nxt_winner = (score_r == WIN);
                    end else begin
                        nxt_state = ST_SERVE;
                    end
                end
            end
            default: nxt_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_IDLE;
            start_q   <= 1'b0;
            score_l   <= '0;
            score_r   <= '0;
            serve_dir <= LEFT;
            game_over <= 1'b0;
            winner    <= 1'b0;
            ball_hold <= 1'b1;
            ball_en   <= 1'b0;
        end else begin
            state     <= nxt_state;
            start_q   <= start;
            score_l   <= nxt_score_l;
            score_r   <= nxt_score_r;
            serve_dir <= nxt_dir;
            game_over <= nxt_over;
            winner    <= nxt_winner;
            ball_hold <= (nxt_state == ST_IDLE) || (nxt_state == ST_SERVE) || (nxt_state == ST_OVER);
            ball_en   <= (nxt_state == ST_PLAY);
        end
    end

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl with default parameters (win 7, serve 60, point 90).
module tb_game_ctrl;

    logic       clk = 1'b0;
    logic       reset, frame_tick, start, goal_l, goal_r;
    logic       ball_hold, ball_en, serve_dir, game_over, winner;
    logic [3:0] score_l, score_r;
    logic [2:0] state_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    game_ctrl #(.WIN_SCORE(7), .SERVE_FRAMES(60), .POINT_FRAMES(90)) dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .start      (start),
        .goal_l     (goal_l),
        .goal_r     (goal_r),
        .ball_hold  (ball_hold),
        .ball_en    (ball_en),
        .serve_dir  (serve_dir),
        .score_l    (score_l),
        .score_r    (score_r),
        .state_o    (state_o),
        .game_over  (game_over),
        .winner     (winner)
    );

    typedef struct {
        logic       tick, st, gl, gr;
        int         reps;
        logic [2:0] state;
        logic [3:0] sl, sr;
        logic       hold, en, dir, go, win;
        string      name;
    } vec_t;

    vec_t tbl [19];

    localparam logic [2:0] IDLE = 3'd0, SERVE = 3'd1, PLAY = 3'd2,
                           PAUSED = 3'd3, POINT = 3'd4, OVER = 3'd5;

    // Hold inputs for n cycles, then return them to idle; sampled #1 after the edge.
    task automatic apply(input logic t, input logic s, input logic l, input logic r, input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = t; start = s; goal_l = l; goal_r = r;
            @(posedge clk);
            #1;
        end
        frame_tick = 0; start = 0; goal_l = 0; goal_r = 0;
    endtask

    task automatic check(input string name, input logic [2:0] st, input logic [3:0] sl,
                         input logic [3:0] sr, input logic h, input logic e, input logic d,
                         input logic go, input logic w);
        logic [15:0] act, exp;
        act = {state_o, score_l, score_r, ball_hold, ball_en, serve_dir, game_over, go ? winner : 1'b0};
        exp = {st, sl, sr, h, e, d, go, w};
        checks++;
        if (act !== exp || (ball_hold && ball_en)) begin
            failures++;
            $display("FAIL %s: got state=%0d sl=%0d sr=%0d hold=%b en=%b dir=%b over=%b win=%b, want state=%0d sl=%0d sr=%0d hold=%b en=%b dir=%b over=%b win=%b",
                     name, state_o, score_l, score_r, ball_hold, ball_en, serve_dir, game_over, winner,
                     st, sl, sr, h, e, d, go, w);
        end
    endtask

    initial begin
        //            tick st gl gr reps state  sl sr hold en dir go win
        tbl[0]  = '{0, 1, 0, 0,  1, SERVE,  0, 0, 1, 0, 0, 0, 0, "start_to_serve"};
        tbl[1]  = '{1, 0, 0, 0, 59, SERVE,  0, 0, 1, 0, 0, 0, 0, "serve_59_ticks"};
        tbl[2]  = '{1, 0, 0, 0,  1, PLAY,   0, 0, 0, 1, 0, 0, 0, "serve_60th_tick"};
        tbl[3]  = '{0, 0, 0, 1,  1, POINT,  1, 0, 0, 0, 0, 0, 0, "goal_r_scores_l"};
        tbl[4]  = '{1, 0, 0, 0, 89, POINT,  1, 0, 0, 0, 0, 0, 0, "point_89_ticks"};
        tbl[5]  = '{1, 0, 0, 0,  1, SERVE,  1, 0, 1, 0, 0, 0, 0, "point_90th_tick"};
        tbl[6]  = '{1, 0, 0, 0, 60, PLAY,   1, 0, 0, 1, 0, 0, 0, "serve_again"};
        tbl[7]  = '{0, 0, 1, 1,  1, POINT,  1, 0, 0, 0, 0, 0, 0, "double_goal"};
        tbl[8]  = '{1, 0, 0, 0, 90, SERVE,  1, 0, 1, 0, 0, 0, 0, "point_done2"};
        tbl[9]  = '{1, 0, 0, 0, 60, PLAY,   1, 0, 0, 1, 0, 0, 0, "serve_done3"};
        tbl[10] = '{0, 1, 0, 0,  1, PAUSED, 1, 0, 0, 0, 0, 0, 0, "pause"};
        tbl[11] = '{0, 0, 1, 0,  1, PAUSED, 1, 0, 0, 0, 0, 0, 0, "goal_in_pause"};
        tbl[12] = '{1, 0, 0, 0,  5, PAUSED, 1, 0, 0, 0, 0, 0, 0, "ticks_in_pause"};
        tbl[13] = '{0, 1, 0, 0,  1, PLAY,   1, 0, 0, 1, 0, 0, 0, "resume"};
        tbl[14] = '{0, 0, 1, 0,  1, POINT,  1, 1, 0, 0, 1, 0, 0, "goal_l_scores_r"};
        tbl[15] = '{1, 0, 0, 0, 90, SERVE,  1, 1, 1, 0, 1, 0, 0, "point_done4"};
        tbl[16] = '{1, 0, 0, 0, 60, PLAY,   1, 1, 0, 1, 1, 0, 0, "serve_done5"};
        tbl[17] = '{0, 1, 1, 0,  1, POINT,  1, 2, 0, 0, 1, 0, 0, "goal_beats_start"};
        tbl[18] = '{1, 0, 0, 0, 90, SERVE,  1, 2, 1, 0, 1, 0, 0, "point_done6"};

        reset = 0; frame_tick = 0; start = 0; goal_l = 0; goal_r = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1;
        check("reset_state", IDLE, 0, 0, 1, 0, 0, 0, 0);
        apply(1, 0, 1, 1, 3);
        check("idle_ignores", IDLE, 0, 0, 1, 0, 0, 0, 0);

        foreach (tbl[i])
            begin
                apply(tbl[i].tick, tbl[i].st, tbl[i].gl, tbl[i].gr, tbl[i].reps);
                check(tbl[i].name, tbl[i].state, tbl[i].sl, tbl[i].sr, tbl[i].hold,
                      tbl[i].en, tbl[i].dir, tbl[i].go, tbl[i].win);
            end

        // Right player wins the match from 1:2.
        for (int k = 3; k <= 7; k++) begin
            apply(1, 0, 0, 0, 60);
            check("rally_play", PLAY, 1, 4'(k - 1), 0, 1, 1, 0, 0);
            apply(0, 0, 1, 0, 1);
            check("rally_goal", POINT, 1, 4'(k), 0, 0, 1, 0, 0);
            apply(1, 0, 0, 0, 89);
            check("rally_freeze", POINT, 1, 4'(k), 0, 0, 1, 0, 0);
            apply(1, 0, 0, 0, 1);
            if (k < 7) check("rally_serve", SERVE, 1, 4'(k), 1, 0, 1, 0, 0);
            else       check("match_over", OVER, 1, 7, 1, 0, 1, 1, 1);
        end
        apply(1, 0, 1, 0, 3);
        check("over_holds", OVER, 1, 7, 1, 0, 1, 1, 1);
        apply(0, 1, 0, 0, 1);
        check("restart", SERVE, 0, 0, 1, 0, 0, 0, 0);
        apply(0, 1, 0, 0, 1);
        check("start_in_serve", SERVE, 0, 0, 1, 0, 0, 0, 0);
        apply(1, 0, 0, 0, 60);
        check("restart_play", PLAY, 0, 0, 0, 1, 0, 0, 0);
        apply(0, 0, 0, 1, 1);
        check("restart_goal", POINT, 1, 0, 0, 0, 0, 0, 0);
        apply(1, 1, 0, 0, 10);
        check("start_in_point", POINT, 1, 0, 0, 0, 0, 0, 0);
        reset = 0;
        apply(1, 0, 0, 0, 1);
        reset = 1;
        check("reset_mid_point", IDLE, 0, 0, 1, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
